// File: rtl/if_id_hazard_pkg.sv
// Shared encodings for the IF/ID register and its hazard control.
package if_id_hazard_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] FUNCT_JR = 6'h08;

  // Fetch-hold request sent back to the NPC/PC logic.
  typedef enum logic [1:0] {
    INSTAL_RUN   = 2'b00,
    INSTAL_LDUSE = 2'b01,
    INSTAL_BRDEP = 2'b10
  } instal_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HOLD2 = 2'b01,
    ST_HOLD1 = 2'b10
  } state_e;

  // Instruction fields the hazard logic looks at.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [OP_W-1:0]  funct;
  } id_fields_t;

endpackage

// File: rtl/if_id_hazard_hazard_detect.sv
// Combinational hold-length and ID-branch detection for the instruction in ID.
module hazard_detect
  import if_id_hazard_pkg::*;
(
  input  logic             id_valid,
  input  id_fields_t       fields,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_memread,
  input  logic [REG_W-1:0] mem_rd,
  output logic [1:0]       hold_len_c,
  output logic             br_id_c
);

  logic uses_rt;
  logic is_jr;
  logic ex_hit;
  logic mem_hit;

  // Register r is a source of the instruction in ID ($0 never is).
  function automatic logic reg_match(input logic [REG_W-1:0] r,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             rt_used);
    return (r != '0) && ((r == rs) || (rt_used && (r == rt)));
  endfunction

  // Decode source usage and producer matches, then pick the hold length.
  always_comb begin
    uses_rt    = (fields.op == OP_RTYPE) || (fields.op == OP_BEQ) ||
                 (fields.op == OP_BNE)   || (fields.op == OP_SW);
    is_jr      = (fields.op == OP_RTYPE) && (fields.funct == FUNCT_JR);
    br_id_c    = id_valid && ((fields.op == OP_BEQ) || (fields.op == OP_BNE) || is_jr);
    ex_hit     = id_valid && reg_match(ex_rd, fields.rs, fields.rt, uses_rt);
    mem_hit    = id_valid && reg_match(mem_rd, fields.rs, fields.rt, uses_rt);
    hold_len_c = 2'd0;
    if (br_id_c && ex_memread && ex_hit) begin
      hold_len_c = 2'd2;
    end else if ((!br_id_c && ex_memread && ex_hit) ||
                 (br_id_c && ex_regwrite && !ex_memread && ex_hit) ||
                 (br_id_c && mem_memread && mem_hit)) begin
      hold_len_c = 2'd1;
    end
  end

endmodule

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use / ID-branch hold control and perf counters.
module if_id_hazard
  import if_id_hazard_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic [INSTR_W-1:0] if_pc4,
  input  logic               if_flush,
  input  logic               ex_regwrite,
  input  logic               ex_memread,
  input  logic [REG_W-1:0]   ex_rd,
  input  logic               mem_memread,
  input  logic [REG_W-1:0]   mem_rd,
  output logic [INSTR_W-1:0] id_instr,
  output logic [INSTR_W-1:0] id_pc4,
  output logic               id_valid,
  output logic [1:0]         instal,
  output logic               idex_bubble,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  state_e     state;
  state_e     state_nxt;
  id_fields_t fields;
  logic [1:0] hold_len_c;
  logic       br_id_c;
  logic       hold_c;

  assign fields = '{op:    id_instr[31:26],
                    rs:    id_instr[25:21],
                    rt:    id_instr[20:16],
                    funct: id_instr[5:0]};

  hazard_detect u_hazard_detect (
    .id_valid    (id_valid),
    .fields      (fields),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .mem_memread (mem_memread),
    .mem_rd      (mem_rd),
    .hold_len_c  (hold_len_c),
    .br_id_c     (br_id_c)
  );

  // Hold-sequence state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and hold outputs; hazards are only sampled in RUN.
  always_comb begin
    state_nxt   = state;
    hold_c      = 1'b0;
    instal      = INSTAL_RUN;
    idex_bubble = 1'b0;
    case (state)
      ST_RUN: begin
        if (hold_len_c == 2'd2) begin
          hold_c    = 1'b1;
          state_nxt = ST_HOLD2;
        end else if (hold_len_c == 2'd1) begin
          hold_c    = 1'b1;
          state_nxt = ST_HOLD1;
        end
      end
      ST_HOLD2: begin
        hold_c    = 1'b1;
        state_nxt = ST_HOLD1;
      end
      ST_HOLD1: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
    if (hold_c) begin
      instal      = br_id_c ? INSTAL_BRDEP : INSTAL_LDUSE;
      idex_bubble = 1'b1;
    end
  end

  // IF/ID register: hold keeps contents, flush loads a NOP marked invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_instr <= NOP_INSTR;
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else if (!hold_c) begin
      id_pc4 <= if_pc4;
      if (if_flush) begin
        id_instr <= NOP_INSTR;
        id_valid <= 1'b0;
      end else begin
        id_instr <= if_instr;
        id_valid <= 1'b1;
      end
    end
  end

  // Saturating stall and accepted-flush counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hold_c && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!hold_c && if_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_id_hazard.sv
// Scoreboard bench for if_id_hazard: directed vectors push expectations, a negedge monitor checks them.
module tb_if_id_hazard;

  localparam int unsigned CNT_W = 6;

  localparam logic [31:0] I_ADD = 32'h0044_1820; // add $3,$2,$4
  localparam logic [31:0] I_LW  = 32'h8D28_0000; // lw  $8,0($9)
  localparam logic [31:0] I_BEQ = 32'h10A6_0000; // beq $5,$6,0
  localparam logic [31:0] I_JR7 = 32'h00E0_0008; // jr  $7
  localparam logic [31:0] I_JR0 = 32'h0000_0008; // jr  $0

  typedef struct packed {
    logic [31:0]      instr;
    logic [31:0]      pc4;
    logic             valid;
    logic [1:0]       instal;
    logic             bubble;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [31:0]      if_instr = '0;
  logic [31:0]      if_pc4 = '0;
  logic             if_flush = 1'b0;
  logic             ex_regwrite = 1'b0;
  logic             ex_memread = 1'b0;
  logic [4:0]       ex_rd = '0;
  logic             mem_memread = 1'b0;
  logic [4:0]       mem_rd = '0;
  logic [31:0]      id_instr;
  logic [31:0]      id_pc4;
  logic             id_valid;
  logic [1:0]       instal;
  logic             idex_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   vec_idx = 0;

  if_id_hazard #(.NOP_INSTR(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_instr    (if_instr),
    .if_pc4      (if_pc4),
    .if_flush    (if_flush),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .mem_memread (mem_memread),
    .mem_rd      (mem_rd),
    .id_instr    (id_instr),
    .id_pc4      (id_pc4),
    .id_valid    (id_valid),
    .instal      (instal),
    .idex_bubble (idex_bubble),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, vec_idx, act, exp);
    end
  endtask

  // Apply one cycle of inputs just after the rising edge.
  task automatic drv(input logic r, input logic fl, input logic [31:0] ins, input logic [31:0] pc,
                     input logic erw, input logic emr, input logic [4:0] erd,
                     input logic mmr, input logic [4:0] mrd);
    @(posedge clk);
    #1;
    rst         = r;
    if_flush    = fl;
    if_instr    = ins;
    if_pc4      = pc;
    ex_regwrite = erw;
    ex_memread  = emr;
    ex_rd       = erd;
    mem_memread = mmr;
    mem_rd      = mrd;
  endtask

  // Expected outputs for the cycle just driven.
  task automatic exp_push(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                          input logic [1:0] inst, input logic bub,
                          input int unsigned st, input int unsigned fc);
    exp_t e;
    e.instr  = ins;
    e.pc4    = pc;
    e.valid  = v;
    e.instal = inst;
    e.bubble = bub;
    e.stall  = CNT_W'(st);
    e.flush  = CNT_W'(fc);
    sb_q.push_back(e);
  endtask

  // Monitor: compare mid-cycle outputs against the oldest expectation.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      cmp("id_instr",    id_instr,             mon_e.instr);
      cmp("id_pc4",      id_pc4,               mon_e.pc4);
      cmp("id_valid",    32'(id_valid),        32'(mon_e.valid));
      cmp("instal",      32'(instal),          32'(mon_e.instal));
      cmp("idex_bubble", 32'(idex_bubble),     32'(mon_e.bubble));
      cmp("stall_cnt",   32'(stall_cnt),       32'(mon_e.stall));
      cmp("flush_cnt",   32'(flush_cnt),       32'(mon_e.flush));
      vec_idx++;
    end
  end

  initial begin
    // reset held, then released
    drv(0,0,I_ADD,32'h100, 0,0,5'd0, 0,5'd0); exp_push(32'h0,32'h0,0,2'b00,0,0,0);
    drv(1,0,I_ADD,32'h104, 0,0,5'd0, 0,5'd0); exp_push(32'h0,32'h0,0,2'b00,0,0,0);
    // load-use: lw $2 in EX, add uses $2 -> one held cycle, HOLD1 ignores hazard
    drv(1,0,I_LW ,32'h108, 1,1,5'd2, 0,5'd0); exp_push(I_ADD,32'h104,1,2'b01,1,0,0);
    drv(1,0,I_LW ,32'h108, 1,1,5'd2, 0,5'd0); exp_push(I_ADD,32'h104,1,2'b00,0,1,0);
    drv(1,0,I_BEQ,32'h10C, 0,0,5'd0, 0,5'd0); exp_push(I_LW ,32'h108,1,2'b00,0,1,0);
    // lw $5 feeding beq in ID -> two held cycles, flush in HOLD2 dropped
    drv(1,0,I_ADD,32'h110, 1,1,5'd5, 0,5'd0); exp_push(I_BEQ,32'h10C,1,2'b10,1,1,0);
    drv(1,1,I_ADD,32'h110, 0,0,5'd0, 0,5'd0); exp_push(I_BEQ,32'h10C,1,2'b10,1,2,0);
    drv(1,0,I_JR7,32'h200, 0,0,5'd0, 1,5'd5); exp_push(I_BEQ,32'h10C,1,2'b00,0,3,0);
    // ALU result feeding jr -> one held cycle
    drv(1,0,I_JR0,32'h204, 1,0,5'd7, 0,5'd0); exp_push(I_JR7,32'h200,1,2'b10,1,3,0);
    drv(1,0,I_JR0,32'h204, 0,0,5'd0, 0,5'd0); exp_push(I_JR7,32'h200,1,2'b00,0,4,0);
    // $0 never matches; accepted flush loads NOP
    drv(1,1,I_LW ,32'h208, 1,0,5'd0, 1,5'd0); exp_push(I_JR0,32'h204,1,2'b00,0,4,0);
    drv(1,0,I_ADD,32'h20C, 0,0,5'd0, 0,5'd0); exp_push(32'h0,32'h208,0,2'b00,0,4,1);
    // MEM load vs non-branch: no hold; MEM load vs beq rt: one held cycle, flush dropped
    drv(1,0,I_BEQ,32'h210, 0,0,5'd0, 1,5'd2); exp_push(I_ADD,32'h20C,1,2'b00,0,4,1);
    drv(1,1,I_LW ,32'h214, 0,0,5'd0, 1,5'd6); exp_push(I_BEQ,32'h210,1,2'b10,1,4,1);
    drv(1,0,I_LW ,32'h214, 0,0,5'd0, 0,5'd0); exp_push(I_BEQ,32'h210,1,2'b00,0,5,1);
    // lw has no rt source: load to $8 does not stall it
    drv(1,0,I_BEQ,32'h218, 1,1,5'd8, 0,5'd0); exp_push(I_LW ,32'h214,1,2'b00,0,5,1);
    drv(1,0,I_BEQ,32'h21C, 1,1,5'd5, 0,5'd0); exp_push(I_BEQ,32'h218,1,2'b10,1,5,1);
    // reset asserted while in HOLD2 takes effect before any edge
    drv(0,0,I_BEQ,32'h21C, 1,1,5'd5, 0,5'd0); exp_push(32'h0,32'h0,0,2'b00,0,0,0);
    drv(1,0,I_ADD,32'h300, 0,0,5'd0, 0,5'd0); exp_push(32'h0,32'h0,0,2'b00,0,0,0);
    drv(1,0,I_BEQ,32'h304, 0,0,5'd0, 0,5'd0); exp_push(I_ADD,32'h300,1,2'b00,0,0,0);
    // 68 held cycles, then 67 flushes: both counters pin at all-ones
    for (int i = 0; i < 102; i++) drv(1,0,I_BEQ,32'h304, 1,1,5'd5, 0,5'd0);
    for (int i = 0; i < 67; i++)  drv(1,1,I_LW ,32'h400, 0,0,5'd0, 0,5'd0);
    drv(1,0,I_ADD,32'h404, 0,0,5'd0, 0,5'd0);
    exp_push(32'h0,32'h400,0,2'b00,0,(1 << CNT_W) - 1,(1 << CNT_W) - 1);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
